// File: rtl/voice_allocator_pkg.sv
// Shared types and constant tables for the voice allocator: note ratios,
// scancode-to-semitone map, key event record and FSM state encoding.
package voice_allocator_pkg;

    localparam int NUM_NOTES = 13;

    // Just-intonation ratios of semitones 0..12 relative to semitone 0, Q12.20 (truncated).
    localparam logic [31:0] NOTE_RATIO_Q20 [0:NUM_NOTES-1] = '{
        32'h0010_0000,  // 1/1
        32'h0011_1111,  // 16/15
        32'h0012_0000,  // 9/8
        32'h0013_3333,  // 6/5
        32'h0014_0000,  // 5/4
        32'h0015_5555,  // 4/3
        32'h0016_8000,  // 45/32
        32'h0018_0000,  // 3/2
        32'h0019_9999,  // 8/5
        32'h001A_AAAA,  // 5/3
        32'h001C_CCCC,  // 9/5
        32'h001E_0000,  // 15/8
        32'h0020_0000   // 2/1
    };

    // PS/2 set-2 scancodes of the keys playing semitones 0..12.
    localparam logic [7:0] SCANCODE_MAP [0:NUM_NOTES-1] = '{
        8'h15, 8'h16, 8'h1D, 8'h26, 8'h24, 8'h2D, 8'h2E,
        8'h2C, 8'h36, 8'h35, 8'h3D, 8'h3C, 8'h43
    };

    // Bit order matches ps2_key[9:0] so the port slice casts directly.
    typedef struct packed {
        logic       pressed;
        logic       extended;
        logic [7:0] scancode;
    } key_evt_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DECODE,
        ST_SCAN,
        ST_COMMIT
    } alloc_state_e;

    // Voice age counter that sticks at its maximum instead of wrapping.
    function automatic logic [7:0] age_inc(input logic [7:0] age);
        return (age == 8'hFF) ? age : age + 8'd1;
    endfunction

endpackage

// File: rtl/voice_allocator_if.sv
// Key-event input and per-voice output bundle between hps_io glue and the
// synthesizer. Handshake: none -- ps2_key is a level bus whose bit 10 toggles
// once per new key event; every output is a registered level except
// event_dropped, which is a one-cycle pulse. dbg_state mirrors the FSM state.
interface voice_allocator_if
    import voice_allocator_pkg::*;
#(
    parameter int NUM_VOICES = 8
) ();
    logic [10:0]                 ps2_key;
    logic [NUM_VOICES-1:0][31:0] frequencies;
    logic [NUM_VOICES-1:0][31:0] voice_volumes;
    logic                        busy;
    logic [4:0]                  active_count;
    logic                        event_dropped;
    alloc_state_e                dbg_state;

    modport master (
        output ps2_key,
        input  frequencies, voice_volumes, busy, active_count, event_dropped, dbg_state
    );

    modport slave (
        input  ps2_key,
        output frequencies, voice_volumes, busy, active_count, event_dropped, dbg_state
    );
endinterface

// File: rtl/voice_allocator_scancode_note_lut.sv
// Combinational scancode -> semitone lookup; valid is low for unmapped keys.
module scancode_note_lut
    import voice_allocator_pkg::*;
(
    input  logic [7:0] scancode,
    output logic       valid,
    output logic [3:0] note
);

    // Linear match against the 13-entry map; entries are distinct so at most one hits.
    always_comb begin
        valid = 1'b0;
        note  = 4'd0;
        for (int i = 0; i < NUM_NOTES; i++) begin
            if (scancode == SCANCODE_MAP[i]) begin
                valid = 1'b1;
                note  = 4'(i);
            end
        end
    end

endmodule

// File: rtl/voice_allocator.sv
// Turns PS/2 key events into per-voice frequency/volume words. Presses take
// the lowest free voice or steal the oldest; releases silence every voice
// playing the released frequency. Voices are examined one per cycle.
module voice_allocator
    import voice_allocator_pkg::*;
#(
    parameter int          NUM_VOICES = 8,
    parameter int          BASE_HZ    = 110,
    parameter logic [31:0] VOL_ON     = 32'h0010_0000
) (
    input logic              clk_sys,
    input logic              reset_n,
    voice_allocator_if.slave bus
);

    localparam int IW = $clog2(NUM_VOICES);

    alloc_state_e                state;
    logic                        armed;
    logic                        prev_toggle;
    logic                        pend_valid;
    key_evt_t                    pend_evt;
    key_evt_t                    cur_evt;
    key_evt_t                    in_evt;
    logic                        toggle_evt;
    logic                        busy_q;
    logic                        dropped_q;
    logic [31:0]                 freq_reg;
    logic [IW-1:0]               scan_idx;
    logic                        hit;
    logic                        free_found;
    logic [IW-1:0]               free_idx;
    logic [IW-1:0]               oldest_idx;
    logic [7:0]                  oldest_age;
    logic [IW-1:0]               target;
    logic [NUM_VOICES-1:0][31:0] freq_q, freq_nxt;
    logic [NUM_VOICES-1:0][31:0] vol_q, vol_nxt;
    logic [NUM_VOICES-1:0][7:0]  age_q, age_nxt;
    logic [4:0]                  active_q, count_nxt;
    logic                        lut_valid;
    logic [3:0]                  lut_note;

    assign in_evt     = key_evt_t'(bus.ps2_key[9:0]);
    assign toggle_evt = armed && (bus.ps2_key[10] != prev_toggle);

    scancode_note_lut u_lut (
        .scancode (cur_evt.scancode),
        .valid    (lut_valid),
        .note     (lut_note)
    );

    // Voice table after applying the current event; only latched in COMMIT.
    always_comb begin
        freq_nxt  = freq_q;
        vol_nxt   = vol_q;
        age_nxt   = age_q;
        target    = free_found ? free_idx : oldest_idx;
        count_nxt = 5'd0;
        if (cur_evt.pressed) begin
            if (!hit) begin
                for (int i = 0; i < NUM_VOICES; i++) begin
                    if (IW'(i) == target) begin
                        freq_nxt[i] = freq_reg;
                        vol_nxt[i]  = VOL_ON;
                        age_nxt[i]  = 8'd0;
                    end else if (vol_q[i] != '0) begin
                        age_nxt[i]  = age_inc(age_q[i]);
                    end
                end
            end
        end else begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (freq_q[i] == freq_reg) vol_nxt[i] = '0;
            end
        end
        for (int i = 0; i < NUM_VOICES; i++) begin
            count_nxt = count_nxt + 5'(vol_nxt[i] != '0);
        end
    end

    // Event capture, pending slot and the IDLE/DECODE/SCAN/COMMIT sequencer.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            armed       <= 1'b0;
            prev_toggle <= 1'b0;
            pend_valid  <= 1'b0;
            pend_evt    <= '0;
            cur_evt     <= '0;
            busy_q      <= 1'b0;
            dropped_q   <= 1'b0;
            freq_reg    <= '0;
            scan_idx    <= '0;
            hit         <= 1'b0;
            free_found  <= 1'b0;
            free_idx    <= '0;
            oldest_idx  <= '0;
            oldest_age  <= '0;
            freq_q      <= '0;
            vol_q       <= '0;
            age_q       <= '0;
            active_q    <= '0;
        end else begin
            armed       <= 1'b1;
            prev_toggle <= bus.ps2_key[10];
            dropped_q   <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (pend_valid) begin
                        cur_evt    <= pend_evt;
                        pend_valid <= 1'b0;
                        state      <= ST_DECODE;
                        busy_q     <= 1'b1;
                    end else if (toggle_evt) begin
                        cur_evt <= in_evt;
                        state   <= ST_DECODE;
                        busy_q  <= 1'b1;
                    end
                end
                ST_DECODE: begin
                    if (cur_evt.extended || !lut_valid) begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        freq_reg   <= 32'(64'(NOTE_RATIO_Q20[lut_note]) * 64'(BASE_HZ));
                        scan_idx   <= '0;
                        hit        <= 1'b0;
                        free_found <= 1'b0;
                        free_idx   <= '0;
                        oldest_idx <= '0;
                        oldest_age <= '0;
                        state      <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if ((vol_q[scan_idx] != '0) && (freq_q[scan_idx] == freq_reg)) hit <= 1'b1;
                    if ((vol_q[scan_idx] == '0) && !free_found) begin
                        free_found <= 1'b1;
                        free_idx   <= scan_idx;
                    end
                    // Strictly-greater keeps the lowest index on equal ages.
                    if (age_q[scan_idx] > oldest_age) begin
                        oldest_age <= age_q[scan_idx];
                        oldest_idx <= scan_idx;
                    end
                    if (scan_idx == IW'(NUM_VOICES - 1)) state <= ST_COMMIT;
                    else                                 scan_idx <= scan_idx + IW'(1);
                end
                ST_COMMIT: begin
                    freq_q   <= freq_nxt;
                    vol_q    <= vol_nxt;
                    age_q    <= age_nxt;
                    active_q <= count_nxt;
                    state    <= ST_IDLE;
                    busy_q   <= 1'b0;
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
            endcase

            // Events that cannot start the FSM directly queue in the single slot.
            // In IDLE the slot is being drained this cycle, so it can be refilled.
            if (toggle_evt && !(state == ST_IDLE && !pend_valid)) begin
                if (!pend_valid || state == ST_IDLE) begin
                    pend_evt   <= in_evt;
                    pend_valid <= 1'b1;
                end else begin
                    dropped_q  <= 1'b1;
                end
            end
        end
    end

    assign bus.frequencies   = freq_q;
    assign bus.voice_volumes = vol_q;
    assign bus.busy          = busy_q;
    assign bus.active_count  = active_q;
    assign bus.event_dropped = dropped_q;
    assign bus.dbg_state     = state;

endmodule

// File: tb/tb_voice_allocator.sv
// Bench for voice_allocator: directed scenarios plus random key traffic,
// checked against a voice-table model built from musical ratios and press order.
module tb_voice_allocator;

    localparam int          NV  = 8;
    localparam logic [31:0] VOL = 32'h0010_0000;

    // ---------------- clock / reset ----------------
    logic clk_sys = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk_sys = ~clk_sys;

    voice_allocator_if #(.NUM_VOICES(NV)) bus ();

    voice_allocator #(
        .NUM_VOICES (NV),
        .BASE_HZ    (110),
        .VOL_ON     (VOL)
    ) dut (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int   n_cmp = 0;
    int   n_mis = 0;
    int   drop_seen = 0;
    int   busy_seen = 0;
    logic tog = 1'b0;

    logic [7:0] key_map   [13] = '{8'h15, 8'h16, 8'h1D, 8'h26, 8'h24, 8'h2D, 8'h2E,
                                   8'h2C, 8'h36, 8'h35, 8'h3D, 8'h3C, 8'h43};
    int         ratio_num [13] = '{1, 16, 9, 6, 5, 4, 45, 3, 8, 5, 9, 15, 2};
    int         ratio_den [13] = '{1, 15, 8, 5, 4, 3, 32, 2, 5, 3, 5, 8, 1};

    // ---------------- reference model ----------------
    logic [31:0] m_freq  [NV];
    logic [31:0] m_vol   [NV];
    int          m_stamp [NV];
    int          m_seq;

    always @(negedge clk_sys) begin
        if (bus.event_dropped === 1'b1) drop_seen++;
        if (bus.busy === 1'b1)          busy_seen++;
    end

    function automatic logic [31:0] note_freq(input int note);
        logic [63:0] ratio;
        ratio = (64'(ratio_num[note]) << 20) / 64'(ratio_den[note]);
        return 32'(ratio * 64'd110);
    endfunction

    function automatic int note_of(input logic [7:0] sc);
        int n = -1;
        for (int i = 0; i < 13; i++) if (key_map[i] == sc) n = i;
        return n;
    endfunction

    function automatic void model_reset();
        for (int v = 0; v < NV; v++) begin
            m_freq[v] = '0; m_vol[v] = '0; m_stamp[v] = 0;
        end
        m_seq = 1;
    endfunction

    // Press: already sounding -> nothing; else first silent voice, else the
    // voice pressed longest ago. Release: silence all voices at that pitch.
    function automatic void model_apply(input bit pressed, input bit ext, input logic [7:0] sc);
        int note, tgt;
        logic [31:0] f;
        note = note_of(sc);
        if (ext || note < 0) return;
        f = note_freq(note);
        if (pressed) begin
            for (int v = 0; v < NV; v++) if (m_vol[v] != 0 && m_freq[v] == f) return;
            tgt = -1;
            for (int v = 0; v < NV; v++) if (m_vol[v] == 0 && tgt < 0) tgt = v;
            if (tgt < 0) begin
                tgt = 0;
                for (int v = 1; v < NV; v++) if (m_stamp[v] < m_stamp[tgt]) tgt = v;
            end
            m_freq[tgt] = f; m_vol[tgt] = VOL; m_stamp[tgt] = m_seq; m_seq++;
        end else begin
            for (int v = 0; v < NV; v++) if (m_freq[v] == f) m_vol[v] = '0;
        end
    endfunction

    function automatic logic [NV-1:0][31:0] exp_freqs();
        logic [NV-1:0][31:0] r;
        for (int v = 0; v < NV; v++) r[v] = m_freq[v];
        return r;
    endfunction

    function automatic logic [NV-1:0][31:0] exp_vols();
        logic [NV-1:0][31:0] r;
        for (int v = 0; v < NV; v++) r[v] = m_vol[v];
        return r;
    endfunction

    function automatic logic [4:0] exp_active();
        int c = 0;
        for (int v = 0; v < NV; v++) if (m_vol[v] != 0) c++;
        return 5'(c);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        reset_n = 1'b0;
        bus.ps2_key = {tog, 10'h000};
        repeat (3) @(posedge clk_sys);
        #1 reset_n = 1'b1;
        model_reset();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic send_key(input bit pressed, input bit ext, input logic [7:0] sc);
        @(posedge clk_sys);
        #1;
        tog = ~tog;
        bus.ps2_key = {tog, pressed, ext, sc};
    endtask

    task automatic wait_idle();
        int quiet = 0;
        int cyc = 0;
        while (quiet < 3 && cyc < 300) begin
            @(posedge clk_sys);
            #1;
            cyc++;
            if (bus.busy === 1'b0) quiet++;
            else                   quiet = 0;
        end
        n_cmp++;
        if (quiet < 3) begin
            n_mis++;
            $display("FAIL idle_timeout: busy=%b after %0d cycles, required 0", bus.busy, cyc);
        end
    endtask

    task automatic play(input bit pressed, input bit ext, input logic [7:0] sc);
        send_key(pressed, ext, sc);
        model_apply(pressed, ext, sc);
        wait_idle();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        bus.ps2_key = '0;
        repeat (3) @(posedge clk_sys);
        #1;
        n_cmp++; if (bus.frequencies !== '0) begin n_mis++; $display("FAIL reset_freq: got %h want 0", bus.frequencies); end
        n_cmp++; if (bus.voice_volumes !== '0) begin n_mis++; $display("FAIL reset_vol: got %h want 0", bus.voice_volumes); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_mis++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        n_cmp++; if (bus.active_count !== 5'd0) begin n_mis++; $display("FAIL reset_active: got %0d want 0", bus.active_count); end
        n_cmp++; if (bus.event_dropped !== 1'b0) begin n_mis++; $display("FAIL reset_dropped: got %b want 0", bus.event_dropped); end
    endtask

    task automatic test_first_press();
        do_reset();
        send_key(1'b1, 1'b0, 8'h15);
        model_apply(1'b1, 1'b0, 8'h15);
        for (int k = 1; k <= 11; k++) begin
            @(posedge clk_sys);
            #1;
            if (k == 10) begin
                n_cmp++; if (bus.voice_volumes[0] !== 32'h0) begin n_mis++; $display("FAIL early_update: vol0 %h at T+10, want 0", bus.voice_volumes[0]); end
            end
        end
        n_cmp++; if (bus.frequencies[0] !== 32'h06E0_0000) begin n_mis++; $display("FAIL first_freq: got %h want 06e00000", bus.frequencies[0]); end
        n_cmp++; if (bus.voice_volumes[0] !== VOL) begin n_mis++; $display("FAIL first_vol: got %h want %h", bus.voice_volumes[0], VOL); end
        n_cmp++; if (bus.active_count !== 5'd1) begin n_mis++; $display("FAIL first_active: got %0d want 1", bus.active_count); end
        wait_idle();
    endtask

    task automatic test_chord_release();
        do_reset();
        play(1'b1, 1'b0, 8'h15);
        play(1'b1, 1'b0, 8'h2C);
        play(1'b1, 1'b0, 8'h43);
        n_cmp++; if (bus.frequencies[0] !== 32'h06E0_0000) begin n_mis++; $display("FAIL chord_f0: got %h want 06e00000", bus.frequencies[0]); end
        n_cmp++; if (bus.frequencies[1] !== 32'h0A50_0000) begin n_mis++; $display("FAIL chord_f1: got %h want 0a500000", bus.frequencies[1]); end
        n_cmp++; if (bus.frequencies[2] !== 32'h0DC0_0000) begin n_mis++; $display("FAIL chord_f2: got %h want 0dc00000", bus.frequencies[2]); end
        n_cmp++; if (bus.active_count !== 5'd3) begin n_mis++; $display("FAIL chord_active: got %0d want 3", bus.active_count); end
        play(1'b0, 1'b0, 8'h2C);
        n_cmp++; if (bus.voice_volumes[1] !== 32'h0) begin n_mis++; $display("FAIL release_vol1: got %h want 0", bus.voice_volumes[1]); end
        n_cmp++; if (bus.frequencies[1] !== 32'h0A50_0000) begin n_mis++; $display("FAIL release_f1_kept: got %h want 0a500000", bus.frequencies[1]); end
        n_cmp++; if (bus.active_count !== 5'd2) begin n_mis++; $display("FAIL release_active: got %0d want 2", bus.active_count); end
    endtask

    task automatic test_steal();
        do_reset();
        for (int n = 0; n < 9; n++) play(1'b1, 1'b0, key_map[n]);
        n_cmp++; if (bus.frequencies[0] !== note_freq(8)) begin n_mis++; $display("FAIL steal_9th: v0 %h want %h", bus.frequencies[0], note_freq(8)); end
        n_cmp++; if (bus.frequencies !== exp_freqs() || bus.voice_volumes !== exp_vols()) begin n_mis++; $display("FAIL steal_table: f %h v %h want f %h v %h", bus.frequencies, bus.voice_volumes, exp_freqs(), exp_vols()); end
        play(1'b1, 1'b0, key_map[9]);
        n_cmp++; if (bus.frequencies[1] !== note_freq(9)) begin n_mis++; $display("FAIL steal_10th: v1 %h want %h", bus.frequencies[1], note_freq(9)); end
        n_cmp++; if (bus.active_count !== 5'd8) begin n_mis++; $display("FAIL steal_active: got %0d want 8", bus.active_count); end
    endtask

    task automatic test_back_to_back();
        int d0;
        do_reset();
        d0 = drop_seen;
        send_key(1'b1, 1'b0, 8'h15);
        model_apply(1'b1, 1'b0, 8'h15);
        send_key(1'b0, 1'b0, 8'h15);
        model_apply(1'b0, 1'b0, 8'h15);
        repeat (2) @(posedge clk_sys);
        send_key(1'b1, 1'b0, 8'h16);   // lands mid-SCAN with the slot full
        wait_idle();
        n_cmp++; if (drop_seen - d0 !== 1) begin n_mis++; $display("FAIL b2b_drop_pulses: got %0d want 1", drop_seen - d0); end
        n_cmp++; if (bus.frequencies[0] !== 32'h06E0_0000 || bus.voice_volumes[0] !== 32'h0) begin n_mis++; $display("FAIL b2b_v0: f %h v %h want 06e00000/0", bus.frequencies[0], bus.voice_volumes[0]); end
        n_cmp++; if (bus.frequencies[1] !== 32'h0) begin n_mis++; $display("FAIL b2b_dropped_applied: v1 f %h want 0", bus.frequencies[1]); end
        n_cmp++; if (bus.frequencies !== exp_freqs() || bus.voice_volumes !== exp_vols() || bus.active_count !== exp_active()) begin n_mis++; $display("FAIL b2b_table: f %h v %h want f %h v %h", bus.frequencies, bus.voice_volumes, exp_freqs(), exp_vols()); end
    endtask

    task automatic test_ignored();
        logic [9:0] evs [3] = '{10'h1_16, 10'h2_1C, 10'h1_15};  // {pressed,ext,sc}
        int b0;
        do_reset();
        play(1'b1, 1'b0, 8'h15);
        for (int i = 0; i < 3; i++) begin
            b0 = busy_seen;
            play(evs[i][9], evs[i][8], evs[i][7:0]);
            n_cmp++; if (busy_seen - b0 > 2) begin n_mis++; $display("FAIL ignored_busy_%0d: %0d cycles, want <=2", i, busy_seen - b0); end
            n_cmp++; if (bus.frequencies !== exp_freqs() || bus.voice_volumes !== exp_vols() || bus.active_count !== exp_active()) begin n_mis++; $display("FAIL ignored_table_%0d: f %h v %h want f %h v %h", i, bus.frequencies, bus.voice_volumes, exp_freqs(), exp_vols()); end
        end
    endtask

    task automatic test_random();
        bit pressed, ext;
        logic [7:0] sc;
        do_reset();
        for (int i = 0; i < 60; i++) begin
            sc      = ($urandom_range(0, 99) < 8) ? 8'h1C : key_map[$urandom_range(0, 12)];
            ext     = ($urandom_range(0, 99) < 8);
            pressed = ($urandom_range(0, 99) < 65);
            play(pressed, ext, sc);
            n_cmp++;
            if (bus.frequencies !== exp_freqs() || bus.voice_volumes !== exp_vols() || bus.active_count !== exp_active()) begin
                n_mis++;
                $display("FAIL random_%0d: f %h v %h n %0d want f %h v %h n %0d", i, bus.frequencies, bus.voice_volumes, bus.active_count, exp_freqs(), exp_vols(), exp_active());
            end
        end
    endtask

    task automatic test_reset_mid_scan();
        int b0;
        tog = 1'b1;
        do_reset();
        play(1'b1, 1'b0, 8'h15);
        send_key(1'b1, 1'b0, 8'h2C);   // toggle bit now held at 1
        repeat (4) @(posedge clk_sys);
        #3 reset_n = 1'b0;
        #1;
        n_cmp++; if (bus.frequencies !== '0 || bus.voice_volumes !== '0) begin n_mis++; $display("FAIL midscan_clear: f %h v %h want 0", bus.frequencies, bus.voice_volumes); end
        n_cmp++; if (bus.busy !== 1'b0 || bus.active_count !== 5'd0) begin n_mis++; $display("FAIL midscan_status: busy %b n %0d want 0/0", bus.busy, bus.active_count); end
        b0 = busy_seen;
        repeat (3) @(posedge clk_sys);
        #1 reset_n = 1'b1;
        model_reset();
        repeat (20) @(posedge clk_sys);
        #1;
        n_cmp++; if (busy_seen - b0 !== 0) begin n_mis++; $display("FAIL rearm_spurious: busy %0d cycles, want 0", busy_seen - b0); end
        n_cmp++; if (bus.frequencies !== '0 || bus.voice_volumes !== '0) begin n_mis++; $display("FAIL rearm_table: f %h v %h want 0", bus.frequencies, bus.voice_volumes); end
        play(1'b1, 1'b0, 8'h16);
        n_cmp++; if (bus.frequencies !== exp_freqs() || bus.voice_volumes !== exp_vols() || bus.active_count !== exp_active()) begin n_mis++; $display("FAIL after_rearm: f %h v %h want f %h v %h", bus.frequencies, bus.voice_volumes, exp_freqs(), exp_vols()); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        model_reset();
        test_reset();
        test_first_press();
        test_chord_release();
        test_steal();
        test_back_to_back();
        test_ignored();
        test_random();
        test_reset_mid_scan();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
